// File: rtl/mux_pkg.sv
// Shared constants and helpers for the round-robin result mux.
// Imported by the arbiter and the mux top level.
package mux_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotate-priority encoder: first asserted req at or after ptr wins.
// Purely combinational; en=0 grants nothing.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int NCH   = 8,
  parameter int SEL_W = clog2(NCH)
) (
  input  logic [NCH-1:0]   req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             en,
  output logic [NCH-1:0]   gnt,
  output logic [SEL_W-1:0] gnt_idx
);

  int   idx;
  logic found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int i = 0; i < NCH; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NCH) idx = idx - NCH;
      if (en && !found && req[SEL_W'(idx)]) begin
        found                = 1'b1;
        gnt[SEL_W'(idx)]     = 1'b1;
        gnt_idx              = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/mux_rr_pipe.sv
// N:1 result mux with direct or round-robin channel select,
// a single registered output stage and valid/ready handshakes.
module mux_rr_pipe
  import mux_pkg::*;
#(
  parameter int NCH   = 8,
  parameter int WIDTH = 32,
  parameter int SEL_W = clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mode,
  input  logic [SEL_W-1:0]     sel,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  output logic [SEL_W-1:0]     out_sel,
  input  logic                 out_ready
);

  logic             load;
  logic             fire;
  logic [NCH-1:0]   gnt_rr;
  logic [NCH-1:0]   gnt_dir;
  logic [NCH-1:0]   grant;
  logic [SEL_W-1:0] rr_idx;
  logic [SEL_W-1:0] gnt_idx;
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] ptr_next;
  logic [WIDTH-1:0] mux_data;

  rr_arbiter #(
    .NCH   (NCH),
    .SEL_W (SEL_W)
  ) u_arb (
    .req     (in_valid),
    .ptr     (rr_ptr),
    .en      (mode == MODE_RR),
    .gnt     (gnt_rr),
    .gnt_idx (rr_idx)
  );

  // Out-of-range sel codes match no channel, so they never grant.
  always_comb begin
    gnt_dir = '0;
    for (int k = 0; k < NCH; k++) begin
      if (mode == MODE_DIRECT && sel == SEL_W'(k) && in_valid[k])
        gnt_dir[k] = 1'b1;
    end
  end

  assign grant    = gnt_dir | gnt_rr;
  assign gnt_idx  = (mode == MODE_RR) ? rr_idx : sel;
  assign load     = ~out_valid | out_ready;
  assign in_ready = (load && !reset) ? grant : '0;
  assign fire     = |in_ready;
  assign ptr_next = (gnt_idx == SEL_W'(NCH - 1)) ? '0 : gnt_idx + 1'b1;

  always_comb begin
    mux_data = '0;
    for (int k = 0; k < NCH; k++)
      mux_data = mux_data | ({WIDTH{grant[k]}} & in_data[k*WIDTH +: WIDTH]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      rr_ptr    <= '0;
    end else if (fire) begin
      out_valid <= 1'b1;
      out_data  <= mux_data;
      out_sel   <= gnt_idx;
      if (mode == MODE_RR) rr_ptr <= ptr_next;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
